// File: rtl/joy_poll_sched.sv
// joy_poll_sched: shares one 40-bit SPI transaction engine between two
// joystick modules. Each poll round selects player 1 then player 2, runs one
// transfer per player, unpacks X/Y/buttons into per-player registers and ends
// with a one-cycle upd_strobe that the cursor updaters use as their tick.
//
// Handshake: spi_start is a one-cycle request issued only while exactly one
// ss_n bit is low; spi_done is a one-cycle completion pulse with spi_rx valid
// in the same cycle, and it is honoured only in WAIT (ignored elsewhere).
//
// Select timing: ss_n is a registered output, so it drops one cycle after the
// FSM enters SEL. SEL therefore lasts SETUP_CYC+1 cycles, which keeps ss_n low
// for exactly SETUP_CYC cycles before spi_start and puts the first spi_start
// SETUP_CYC+2 cycles after the poll tick.
module joy_poll_sched #(
    parameter int unsigned POLL_DIV  = 1000000,
    parameter int unsigned SETUP_CYC = 1500,
    parameter int unsigned GAP_CYC   = 1000,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic        spi_start,
    input  logic        spi_done,
    input  logic [39:0] spi_rx,
    output logic [1:0]  ss_n,
    output logic [9:0]  joy1_x,
    output logic [9:0]  joy1_y,
    output logic [9:0]  joy2_x,
    output logic [9:0]  joy2_y,
    output logic [2:0]  btn1,
    output logic [2:0]  btn2,
    output logic        upd_strobe,
    output logic [1:0]  err,
    output logic        ovr
);

    localparam logic [23:0] POLL_LAST  = 24'(POLL_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);
    localparam logic [9:0]  CENTRE     = 10'd512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_START,
        S_WAIT,
        S_LATCH,
        S_GAP,
        S_UPD
    } state_t;

    state_t      state;
    logic [23:0] poll_cnt;
    logic        tick;
    logic        idx;
    logic [15:0] dly;
    logic [9:0]  cap_x;
    logic [9:0]  cap_y;
    logic [2:0]  cap_b;

    // Bytes of the frame that carry no joystick information.
    logic unused_rx;
    assign unused_rx = ^{spi_rx[31:26], spi_rx[15:10], spi_rx[7:3]};

    assign tick = (poll_cnt == POLL_LAST);

    // Free-running poll period counter; runs whether or not polling is enabled.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            poll_cnt <= '0;
        end else if (tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 24'd1;
        end
    end

    // Round sequencer: select, start, wait, latch, gap per player, then strobe.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= S_IDLE;
            idx        <= 1'b0;
            dly        <= '0;
            ss_n       <= 2'b11;
            spi_start  <= 1'b0;
            upd_strobe <= 1'b0;
            err        <= 2'b00;
            ovr        <= 1'b0;
            cap_x      <= '0;
            cap_y      <= '0;
            cap_b      <= '0;
            joy1_x     <= CENTRE;
            joy1_y     <= CENTRE;
            joy2_x     <= CENTRE;
            joy2_y     <= CENTRE;
            btn1       <= 3'd0;
            btn2       <= 3'd0;
        end else begin
            // A tick that cannot start a round is lost; remember that it happened.
            if (tick && en && (state != S_IDLE)) begin
                ovr <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick && en) begin
                        idx   <= 1'b0;
                        dly   <= '0;
                        state <= S_SEL;
                    end
                end

                S_SEL: begin
                    ss_n <= idx ? 2'b01 : 2'b10;
                    if (dly == SETUP_LAST) begin
                        dly       <= '0;
                        spi_start <= 1'b1;
                        state     <= S_START;
                    end else begin
                        dly <= dly + 16'd1;
                    end
                end

                S_START: begin
                    spi_start <= 1'b0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    // Completion takes priority over the timeout on the same cycle.
                    if (spi_done) begin
                        cap_x <= {spi_rx[25:24], spi_rx[39:32]};
                        cap_y <= {spi_rx[9:8], spi_rx[23:16]};
                        cap_b <= spi_rx[2:0];
                        state <= S_LATCH;
                    end else if (dly == WAIT_LAST) begin
                        err[idx] <= 1'b1;
                        ss_n     <= 2'b11;
                        dly      <= '0;
                        state    <= S_GAP;
                    end else begin
                        dly <= dly + 16'd1;
                    end
                end

                S_LATCH: begin
                    if (!idx) begin
                        joy1_x <= cap_x;
                        joy1_y <= cap_y;
                        btn1   <= cap_b;
                    end else begin
                        joy2_x <= cap_x;
                        joy2_y <= cap_y;
                        btn2   <= cap_b;
                    end
                    ss_n  <= 2'b11;
                    dly   <= '0;
                    state <= S_GAP;
                end

                S_GAP: begin
                    if (dly == GAP_LAST) begin
                        dly <= '0;
                        if (!idx) begin
                            idx   <= 1'b1;
                            state <= S_SEL;
                        end else begin
                            upd_strobe <= 1'b1;
                            state      <= S_UPD;
                        end
                    end else begin
                        dly <= dly + 16'd1;
                    end
                end

                S_UPD: begin
                    upd_strobe <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joy_poll_sched.sv
// Bench for joy_poll_sched: vector table of full rounds, hand sequences for
// stray spi_done, en gating, reset mid-WAIT and overrun, then random rounds
// compared against a field-extraction reference model.
module tb_joy_poll_sched;

    localparam int POLL_DIV  = 200;
    localparam int SETUP_CYC = 4;
    localparam int GAP_CYC   = 3;
    localparam int TIMEOUT   = 20;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr;
    logic        en;
    logic        resp_done = 1'b0;
    logic        stray_done = 1'b0;
    logic [39:0] resp_rx = '0;
    logic [39:0] stray_rx = '0;
    logic        spi_done;
    logic [39:0] spi_rx;
    logic        spi_start;
    logic [1:0]  ss_n;
    logic [9:0]  joy1_x, joy1_y, joy2_x, joy2_y;
    logic [2:0]  btn1, btn2;
    logic        upd_strobe;
    logic [1:0]  err;
    logic        ovr;

    assign spi_done = resp_done | stray_done;
    assign spi_rx   = stray_done ? stray_rx : resp_rx;

    joy_poll_sched #(
        .POLL_DIV(POLL_DIV), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .clr(clr), .en(en), .spi_start(spi_start), .spi_done(spi_done),
        .spi_rx(spi_rx), .ss_n(ss_n), .joy1_x(joy1_x), .joy1_y(joy1_y),
        .joy2_x(joy2_x), .joy2_y(joy2_y), .btn1(btn1), .btn2(btn2),
        .upd_strobe(upd_strobe), .err(err), .ovr(ovr)
    );

    // second instance with a poll period shorter than a round
    logic        o_clr;
    logic        o_en;
    logic        o_spi_done = 1'b0;
    logic [39:0] o_spi_rx = '0;
    logic        o_spi_start;
    logic [1:0]  o_ss_n;
    logic [9:0]  o_joy1_x, o_joy1_y, o_joy2_x, o_joy2_y;
    logic [2:0]  o_btn1, o_btn2;
    logic        o_upd;
    logic [1:0]  o_err;
    logic        o_ovr;

    joy_poll_sched #(
        .POLL_DIV(10), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut_o (
        .clk(clk), .clr(o_clr), .en(o_en), .spi_start(o_spi_start), .spi_done(o_spi_done),
        .spi_rx(o_spi_rx), .ss_n(o_ss_n), .joy1_x(o_joy1_x), .joy1_y(o_joy1_y),
        .joy2_x(o_joy2_x), .joy2_y(o_joy2_y), .btn1(o_btn1), .btn2(o_btn2),
        .upd_strobe(o_upd), .err(o_err), .ovr(o_ovr)
    );

    // scoreboard state
    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];
    logic [1:0] ss_log[$];
    logic [1:0] ss_prev = 2'b11;
    int n_start = 0, n_upd = 0, viol = 0;
    int cyc = 0, first_start = -1;
    int o_n_start = 0, o_n_upd = 0, o_rs = 0, o_max = 0;

    // SPI engine configuration per player (index 0 = player 1)
    logic [39:0] cfg_rx[2];
    int          cfg_d[2];
    bit          cfg_drop[2];
    int          resp_p;

    // reference model state
    logic [9:0] m_x[2], m_y[2];
    logic [2:0] m_b[2];
    logic [1:0] m_err;

    typedef struct {
        logic [39:0] rx1;
        logic [39:0] rx2;
        int          d1;
        int          d2;
        bit          drop2;
        logic [9:0]  x1;
        logic [9:0]  y1;
        logic [2:0]  b1;
        logic [9:0]  x2;
        logic [9:0]  y2;
        logic [2:0]  b2;
        logic [1:0]  err;
    } vec_t;
    vec_t vec[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] f_x(input logic [39:0] rx);
        return 10'(((rx >> 24) & 40'd3) * 40'd256 + ((rx >> 32) & 40'd255));
    endfunction
    function automatic logic [9:0] f_y(input logic [39:0] rx);
        return 10'(((rx >> 8) & 40'd3) * 40'd256 + ((rx >> 16) & 40'd255));
    endfunction
    function automatic logic [2:0] f_b(input logic [39:0] rx);
        return 3'(rx & 40'd7);
    endfunction

    // A transfer lands when the engine answers within the allowed WAIT cycles.
    task automatic model_round();
        for (int p = 0; p < 2; p++) begin
            if (!cfg_drop[p] && cfg_d[p] >= 1 && cfg_d[p] <= TIMEOUT) begin
                m_x[p] = f_x(cfg_rx[p]);
                m_y[p] = f_y(cfg_rx[p]);
                m_b[p] = f_b(cfg_rx[p]);
            end else begin
                m_err[p] = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_x[p] = 10'd512;
            m_y[p] = 10'd512;
            m_b[p] = 3'd0;
        end
        m_err = 2'b00;
    endtask

    task automatic compare_model(input string tag);
        check({tag, " joy1_x"}, joy1_x, m_x[0]);
        check({tag, " joy1_y"}, joy1_y, m_y[0]);
        check({tag, " btn1"}, btn1, m_b[0]);
        check({tag, " joy2_x"}, joy2_x, m_x[1]);
        check({tag, " joy2_y"}, joy2_y, m_y[1]);
        check({tag, " btn2"}, btn2, m_b[1]);
        check({tag, " err"}, err, m_err);
        check({tag, " ovr"}, ovr, 1'b0);
    endtask

    task automatic wait_upd(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (upd_strobe) seen = 1;
        end
        #1;
        check({tag, " upd_strobe seen"}, seen, 1'b1);
    endtask

    task automatic wait_start(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (spi_start) seen = 1;
        end
        #1;
        check({tag, " spi_start seen"}, seen, 1'b1);
    endtask

    task automatic pulse_stray(input logic [39:0] data);
        @(posedge clk);
        #1 stray_done = 1'b1;
        stray_rx = data;
        @(posedge clk);
        #1 stray_done = 1'b0;
    endtask

    task automatic set_cfg(input logic [39:0] r1, input logic [39:0] r2,
                           input int d1, input int d2, input bit dr1, input bit dr2);
        cfg_rx[0] = r1; cfg_rx[1] = r2;
        cfg_d[0] = d1;  cfg_d[1] = d2;
        cfg_drop[0] = dr1; cfg_drop[1] = dr2;
    endtask

    // SPI engine model: answer spi_done d cycles after spi_start unless dropped
    initial begin
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                resp_p = (ss_n == 2'b10) ? 0 : 1;
                if (!cfg_drop[resp_p]) begin
                    repeat (cfg_d[resp_p] - 1) @(negedge clk);
                    @(posedge clk);
                    #1 resp_done = 1'b1;
                    resp_rx = cfg_rx[resp_p];
                    @(posedge clk);
                    #1 resp_done = 1'b0;
                end
            end
        end
    end

    // monitors: event counts, select invariants, ss_n change log, start latency
    always @(negedge clk) begin
        if (spi_start) n_start++;
        if (upd_strobe) n_upd++;
        if (ss_n == 2'b00) viol++;
        if (spi_start && ss_n != 2'b10 && ss_n != 2'b01) viol++;
        if (ss_n !== ss_prev) begin
            ss_log.push_back(ss_n);
            ss_prev = ss_n;
        end
        if (clr) begin
            cyc = 0;
        end else begin
            if (spi_start && first_start < 0) first_start = cyc;
            cyc++;
        end
        if (o_ss_n == 2'b00) viol++;
        if (o_spi_start && o_ss_n != 2'b10 && o_ss_n != 2'b01) viol++;
        if (o_spi_start) begin
            o_n_start++;
            o_rs++;
            if (o_rs > o_max) o_max = o_rs;
        end
        if (o_upd) begin
            o_n_upd++;
            o_rs = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, u0;
        vec[0] = '{40'h2A_03_FF_01_05, 40'h00_00_80_02_02, 3, 5, 1'b0,
                   10'h32A, 10'h1FF, 3'd5, 10'h000, 10'h280, 3'd2, 2'b00};
        vec[1] = '{40'hFF_FF_FF_FF_FF, 40'h01_02_03_04_00, 1, 7, 1'b0,
                   10'h3FF, 10'h3FF, 3'd7, 10'h201, 10'h003, 3'd0, 2'b00};
        vec[2] = '{40'h10_00_20_00_03, 40'hAA_AA_AA_AA_AA, 2, 2, 1'b1,
                   10'h010, 10'h020, 3'd3, 10'h201, 10'h003, 3'd0, 2'b10};
        vec[3] = '{40'h00_01_00_02_06, 40'h7F_00_3C_03_01, TIMEOUT, 2, 1'b0,
                   10'h100, 10'h200, 3'd6, 10'h07F, 10'h33C, 3'd1, 2'b10};
        exp_q = '{2'b10, 2'b11, 2'b01, 2'b11};

        clr = 1'b1; en = 1'b1; o_clr = 1'b1; o_en = 1'b0;
        model_reset();
        set_cfg(vec[0].rx1, vec[0].rx2, vec[0].d1, vec[0].d2, 1'b0, vec[0].drop2);
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("post-reset ss_n", ss_n, 2'b11);
        check("post-reset joy1_x", joy1_x, 10'd512);
        check("post-reset upd_strobe", upd_strobe, 1'b0);

        // table-driven full rounds
        for (int i = 0; i < 4; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            set_cfg(vec[i].rx1, vec[i].rx2, vec[i].d1, vec[i].d2, 1'b0, vec[i].drop2);
            ss_log.delete();
            s0 = n_start;
            wait_upd(450, t);
            check({t, " joy1_x"}, joy1_x, vec[i].x1);
            check({t, " joy1_y"}, joy1_y, vec[i].y1);
            check({t, " btn1"}, btn1, vec[i].b1);
            check({t, " joy2_x"}, joy2_x, vec[i].x2);
            check({t, " joy2_y"}, joy2_y, vec[i].y2);
            check({t, " btn2"}, btn2, vec[i].b2);
            check({t, " err"}, err, vec[i].err);
            check({t, " ovr"}, ovr, 1'b0);
            check({t, " starts per round"}, n_start - s0, 2);
            check({t, " ss_n change count"}, ss_log.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < ss_log.size(); k++)
                check($sformatf("%s ss_n step %0d", t, k), ss_log[k], exp_q[k]);
            if (i == 0)
                check("tick to first spi_start", first_start, POLL_DIV - 1 + SETUP_CYC + 2);
            m_x[0] = vec[i].x1; m_y[0] = vec[i].y1; m_b[0] = vec[i].b1;
            m_x[1] = vec[i].x2; m_y[1] = vec[i].y2; m_b[1] = vec[i].b2;
            m_err = vec[i].err;
        end

        // stray spi_done while idle
        pulse_stray(40'hFF_FF_FF_FF_FF);
        repeat (3) @(negedge clk);
        #1;
        compare_model("stray idle");

        // stray spi_done during the gap after player 1
        begin
            bit seen10 = 0, in_gap = 0;
            set_cfg(40'h55_02_66_01_04, 40'h12_01_34_02_03, 2, 2, 1'b0, 1'b0);
            model_round();
            for (int i = 0; i < 400 && !in_gap; i++) begin
                @(negedge clk);
                if (ss_n == 2'b10) seen10 = 1;
                else if (seen10 && ss_n == 2'b11) in_gap = 1;
            end
            check("gap reached", in_gap, 1'b1);
            pulse_stray(40'h00_00_00_00_00);
            wait_upd(200, "stray gap");
            compare_model("stray gap");
        end

        // random rounds against the reference model
        for (int r = 0; r < 15; r++) begin
            set_cfg(40'({$urandom(), $urandom()}), 40'({$urandom(), $urandom()}),
                    $urandom_range(TIMEOUT + 3, 1), $urandom_range(TIMEOUT + 3, 1),
                    $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0);
            model_round();
            s0 = n_start;
            wait_upd(450, $sformatf("rand%0d", r));
            compare_model($sformatf("rand%0d", r));
            check($sformatf("rand%0d starts", r), n_start - s0, 2);
        end

        // en low across several ticks: nothing starts, no overrun
        en = 1'b0;
        s0 = n_start;
        repeat (5 * POLL_DIV + 20) @(negedge clk);
        #1;
        check("en low starts", n_start - s0, 0);
        check("en low ovr", ovr, 1'b0);

        // en dropped mid-WAIT: round completes once, nothing further starts
        set_cfg(40'h3C_02_5A_01_01, 40'h0F_03_F0_00_04, 15, 3, 1'b0, 1'b0);
        model_round();
        s0 = n_start;
        u0 = n_upd;
        en = 1'b1;
        wait_start(250, "en drop");
        repeat (3) @(negedge clk);
        #1 en = 1'b0;
        wait_upd(200, "en drop");
        compare_model("en drop");
        repeat (3 * POLL_DIV) @(negedge clk);
        #1;
        check("en drop starts", n_start - s0, 2);
        check("en drop strobes", n_upd - u0, 1);

        // reset asserted mid-WAIT
        set_cfg(40'h0, 40'h0, 1, 1, 1'b1, 1'b1);
        en = 1'b1;
        wait_start(250, "reset mid-wait");
        repeat (2) @(negedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        check("reset ss_n", ss_n, 2'b11);
        check("reset spi_start", spi_start, 1'b0);
        check("reset upd_strobe", upd_strobe, 1'b0);
        check("reset joy1_x", joy1_x, 10'd512);
        check("reset joy1_y", joy1_y, 10'd512);
        check("reset joy2_x", joy2_x, 10'd512);
        check("reset joy2_y", joy2_y, 10'd512);
        check("reset btn1", btn1, 3'd0);
        check("reset btn2", btn2, 3'd0);
        check("reset err", err, 2'b00);
        check("reset ovr", ovr, 1'b0);
        en = 1'b0;
        @(posedge clk);
        #1 clr = 1'b0;

        // overrun on the short-period instance (engine never answers)
        o_en = 1'b1;
        @(posedge clk);
        #1 o_clr = 1'b0;
        repeat (420) @(negedge clk);
        #1 o_en = 1'b0;
        repeat (150) @(negedge clk);
        #1;
        check("overrun ovr", o_ovr, 1'b1);
        check("overrun starts vs rounds", o_n_start, 2 * o_n_upd);
        check("overrun rounds run", o_n_upd >= 4, 1'b1);
        check("overrun no overlap", o_max <= 2, 1'b1);
        check("overrun err", o_err, 2'b11);
        check("overrun joy1_x", o_joy1_x, 10'd512);

        check("select invariants", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
